// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Imported by dmem_arbiter and rr_arbiter2.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int         LOCK_MAX    = 4;
    localparam logic [2:0] IDLE_FUNCT3 = 3'b010;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
// Combinational grant; the priority pointer advances on every grant.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // index of the requester favoured on a conflict
    logic prio;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (|gnt) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with read-modify-write locking
// and a registered load-return path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [3*NREQ-1:0]    req_funct3,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [31:0]          rdata,
    output logic                 dmem_wren,
    output logic [2:0]           funct3,
    output logic [31:0]          dmem_address,
    output logic [31:0]          dmem_data_in,
    input  logic [31:0]          dmem_data_out
);

    state_t     state, state_n;
    logic [1:0] hold, hold_n;
    logic [1:0] elig;
    logic [1:0] arb_gnt;
    logic       gnt_any;
    logic       sel;

    logic       pend_v [RD_LATENCY];
    logic       pend_o [RD_LATENCY];

    // a lock narrows eligibility to its owner; reset blocks everyone
    always_comb begin
        elig = 2'b11;
        if (reset) begin
            elig = 2'b00;
        end else begin
            unique case (state)
                LOCK0:   elig = 2'b01;
                LOCK1:   elig = 2'b10;
                default: elig = 2'b11;
            endcase
        end
    end

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (req & elig),
        .gnt   (arb_gnt)
    );

    assign gnt     = arb_gnt;
    assign gnt_any = |arb_gnt;
    assign sel     = arb_gnt[1];

    always_comb begin
        dmem_wren    = 1'b0;
        funct3       = IDLE_FUNCT3;
        dmem_address = '0;
        dmem_data_in = '0;
        if (gnt_any) begin
            dmem_wren    = sel ? req_we[1]         : req_we[0];
            funct3       = sel ? req_funct3[5:3]   : req_funct3[2:0];
            dmem_address = sel ? req_addr[63:32]   : req_addr[31:0];
            dmem_data_in = sel ? req_wdata[63:32]  : req_wdata[31:0];
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        unique case (state)
            FREE: begin
                if (arb_gnt[0] && req_lock[0]) begin
                    state_n = LOCK0;
                    hold_n  = 2'd1;
                end else if (arb_gnt[1] && req_lock[1]) begin
                    state_n = LOCK1;
                    hold_n  = 2'd1;
                end
            end
            LOCK0: begin
                if (!arb_gnt[0] || !req_lock[0] ||
                    hold == 2'(LOCK_MAX - 1)) begin
                    state_n = FREE;
                    hold_n  = 2'd0;
                end else begin
                    hold_n  = hold + 2'd1;
                end
            end
            LOCK1: begin
                if (!arb_gnt[1] || !req_lock[1] ||
                    hold == 2'(LOCK_MAX - 1)) begin
                    state_n = FREE;
                    hold_n  = 2'd0;
                end else begin
                    hold_n  = hold + 2'd1;
                end
            end
            default: begin
                state_n = FREE;
                hold_n  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FREE;
            hold  <= 2'd0;
        end else begin
            state <= state_n;
            hold  <= hold_n;
        end
    end

    // load owner travels alongside the memory latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pend_v[i] <= 1'b0;
                pend_o[i] <= 1'b0;
            end
        end else begin
            pend_v[0] <= gnt_any & ~dmem_wren;
            pend_o[0] <= sel;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pend_v[i] <= pend_v[i-1];
                pend_o[i] <= pend_o[i-1];
            end
        end
    end

    always_comb begin
        rvalid = 2'b00;
        rdata  = '0;
        if (pend_v[RD_LATENCY-1] && !reset) begin
            rvalid = pend_o[RD_LATENCY-1] ? 2'b10 : 2'b01;
            rdata  = dmem_data_out;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a
// transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req, req_we, req_lock;
    logic [5:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        dmem_wren;
    logic [2:0]  funct3;
    logic [31:0] dmem_address, dmem_data_in, dmem_data_out;

    dmem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_we        (req_we),
        .req_lock      (req_lock),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .dmem_wren     (dmem_wren),
        .funct3        (funct3),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ma;
    assign ma = dmem_address[7:0];

    function automatic logic [31:0] ext(input logic [31:0] w,
                                        input logic [2:0] f3);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // data memory driven by the DUT's memory port
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (dmem_wren) begin
            mem[ma] <= dmem_data_in[7:0];
            if (funct3[1:0] != 2'd0) mem[ma+8'd1] <= dmem_data_in[15:8];
            if (funct3[1:0] == 2'd2) begin
                mem[ma+8'd2] <= dmem_data_in[23:16];
                mem[ma+8'd3] <= dmem_data_in[31:24];
            end
        end
        dmem_data_out <= ext({mem[ma+8'd3], mem[ma+8'd2],
                              mem[ma+8'd1], mem[ma]}, funct3);
    end

    // model: current lock owner (-1 none), grants in the lock so far,
    // favoured requester, pending load owner and its expected data
    int          owner, run, prio, pend;
    logic [31:0] pend_data;
    logic [1:0]  last_gnt, last_rvalid;
    logic [31:0] last_rdata;
    logic        last_wren;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          g;
        logic [7:0]  a;
        logic [2:0]  f;
        logic [31:0] w;
        @(negedge clk);
        if (reset) g = -1;
        else if (owner >= 0) g = req[owner] ? owner : -1;
        else if (req == 2'b11) g = prio;
        else if (req == 2'b01) g = 0;
        else if (req == 2'b10) g = 1;
        else g = -1;
        chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : 32'(1 << g));
        chk("wren", 32'(dmem_wren), (g < 0) ? 32'd0 : 32'(req_we[g]));
        chk("funct3", 32'(funct3),
            (g < 0) ? 32'd2 : 32'(req_funct3[g*3 +: 3]));
        chk("addr", dmem_address, (g < 0) ? 32'd0 : req_addr[g*32 +: 32]);
        chk("wdata", dmem_data_in, (g < 0) ? 32'd0 : req_wdata[g*32 +: 32]);
        chk("rvalid", 32'(rvalid),
            (!reset && pend >= 0) ? 32'(1 << pend) : 32'd0);
        chk("rdata", rdata, (!reset && pend >= 0) ? pend_data : 32'd0);
        last_gnt    = gnt;
        last_rvalid = rvalid;
        last_rdata  = rdata;
        last_wren   = dmem_wren;
        @(posedge clk);
        if (reset) begin
            owner = -1; run = 0; prio = 0; pend = -1;
        end else begin
            pend = -1;
            if (g >= 0) begin
                a = req_addr[g*32 +: 8];
                f = req_funct3[g*3 +: 3];
                w = req_wdata[g*32 +: 32];
                if (!req_we[g]) begin
                    pend = g;
                    pend_data = ext({ref_mem[a+8'd3], ref_mem[a+8'd2],
                                     ref_mem[a+8'd1], ref_mem[a]}, f);
                end else begin
                    ref_mem[a] = w[7:0];
                    if (f[1:0] != 2'd0) ref_mem[a+8'd1] = w[15:8];
                    if (f[1:0] == 2'd2) begin
                        ref_mem[a+8'd2] = w[23:16];
                        ref_mem[a+8'd3] = w[31:24];
                    end
                end
                prio = 1 - g;
            end
            if (owner < 0) begin
                if (g >= 0 && req_lock[g]) begin
                    owner = g; run = 1;
                end
            end else if (g != owner || !req_lock[owner]) begin
                owner = -1;
            end else begin
                run++;
                if (run == 4) owner = -1;
            end
        end
        #1;
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] we,
                       input logic [1:0] lk, input logic [2:0] f0,
                       input logic [2:0] f1, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] w0,
                       input logic [31:0] w1);
        req        = r;
        req_we     = we;
        req_lock   = lk;
        req_funct3 = {f1, f0};
        req_addr   = {a1, a0};
        req_wdata  = {w1, w0};
    endtask

    task automatic idle();
        drv(2'b00, 2'b00, 2'b00, 3'd2, 3'd2, 0, 0, 0, 0);
    endtask

    logic [1:0] seq36 [4];
    logic [1:0] seq38 [5];
    logic [2:0] st_f3 [3];
    logic [2:0] ld_f3 [5];

    function automatic logic [31:0] rnd_addr(input logic [2:0] f3);
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        seq36 = '{2'b01, 2'b10, 2'b01, 2'b10};
        seq38 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        st_f3 = '{3'd0, 3'd1, 3'd2};
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hEF;
        ref_mem[8'h11] = 8'hBE;
        ref_mem[8'h12] = 8'hAD;
        ref_mem[8'h13] = 8'hDE;
        owner = -1; run = 0; prio = 0; pend = -1; pend_data = '0;

        reset = 1'b1;
        drv(2'b11, 2'b11, 2'b11, 3'd2, 3'd2, 32'h10, 32'h44, 1, 2);
        tick();
        tick();
        chk("rst_gnt", 32'(last_gnt), 32'd0);
        chk("rst_wren", 32'(last_wren), 32'd0);
        reset = 1'b0;

        drv(2'b11, 2'b00, 2'b00, 3'd2, 3'd2, 32'h10, 32'h44, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("conflict_gnt", 32'(last_gnt), 32'(seq36[i]));
        end
        idle();
        tick();
        chk("conflict_tail", 32'(last_rvalid), 32'd2);

        drv(2'b01, 2'b00, 2'b00, 3'd2, 3'd2, 32'h10, 0, 0, 0);
        tick();
        chk("read_gnt", 32'(last_gnt), 32'd1);
        idle();
        tick();
        chk("read_rvalid", 32'(last_rvalid), 32'd1);
        chk("read_rdata", last_rdata, 32'hDEADBEEF);

        drv(2'b01, 2'b01, 2'b00, 3'd2, 3'd2, 32'h40, 0, 32'h12345678, 0);
        tick();
        chk("store_wren0", 32'(last_wren), 32'd1);
        drv(2'b10, 2'b00, 2'b00, 3'd2, 3'd2, 0, 32'h40, 0, 0);
        tick();
        chk("store_wren1", 32'(last_wren), 32'd0);
        chk("store_norv", 32'(last_rvalid), 32'd0);
        idle();
        tick();
        chk("store_rvalid", 32'(last_rvalid), 32'd2);
        chk("store_rdata", last_rdata, 32'h12345678);

        drv(2'b01, 2'b00, 2'b00, 3'd2, 3'd2, 32'h10, 0, 0, 0);
        tick();
        drv(2'b11, 2'b00, 2'b10, 3'd2, 3'd0, 32'h10, 32'h20, 0, 0);
        tick();
        chk("lock_gnt0", 32'(last_gnt), 32'd2);
        drv(2'b11, 2'b10, 2'b00, 3'd2, 3'd0, 32'h10, 32'h20, 0, 32'hA5);
        tick();
        chk("lock_gnt1", 32'(last_gnt), 32'd2);
        drv(2'b01, 2'b00, 2'b00, 3'd2, 3'd0, 32'h10, 32'h20, 0, 0);
        tick();
        chk("lock_gnt2", 32'(last_gnt), 32'd1);
        drv(2'b10, 2'b00, 2'b00, 3'd2, 3'd4, 0, 32'h20, 0, 0);
        tick();
        idle();
        tick();
        chk("lock_byte", last_rdata, 32'h000000A5);

        drv(2'b11, 2'b00, 2'b01, 3'd2, 3'd2, 32'h10, 32'h44, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("timeout_gnt", 32'(last_gnt), 32'(seq38[i]));
        end
        idle();
        tick();

        drv(2'b01, 2'b00, 2'b00, 3'd2, 3'd2, 32'h10, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("rstload_rv1", 32'(last_rvalid), 32'd0);
        reset = 1'b0;
        idle();
        tick();
        chk("rstload_rv2", 32'(last_rvalid), 32'd0);
        drv(2'b11, 2'b00, 2'b00, 3'd2, 3'd2, 32'h10, 32'h44, 0, 0);
        tick();
        chk("rstload_gnt", 32'(last_gnt), 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic [1:0]  we;
            logic [2:0]  f0, f1;
            we    = 2'($urandom);
            f0    = we[0] ? st_f3[$urandom_range(0, 2)]
                          : ld_f3[$urandom_range(0, 4)];
            f1    = we[1] ? st_f3[$urandom_range(0, 2)]
                          : ld_f3[$urandom_range(0, 4)];
            reset = ($urandom_range(0, 39) == 0);
            drv(2'($urandom), we, 2'($urandom), f0, f1,
                rnd_addr(f0), rnd_addr(f1), $urandom, $urandom);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; only 2 is supported.
REQ-002 Parameter RD_LATENCY, default 1, data memory read latency in cycles; only 1 is supported.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req  input  2  bit i = requester i asks for one access this cycle.
REQ-006 Port req_we  input  2  bit i = requester i access is a store.
REQ-007 Port req_lock  input  2  bit i = keep ownership for the following cycle (read-modify-write).
REQ-008 Port req_funct3  input  6  [3i+2:3i] = requester i RISC-V load/store funct3.
REQ-009 Port req_addr  input  64  [32i+31:32i] = requester i byte address.
REQ-010 Port req_wdata  input  64  [32i+31:32i] = requester i store data.
REQ-011 Port gnt  output  2  one-hot-or-zero; access i is issued this cycle.
REQ-012 Port rvalid  output  2  one-hot-or-zero; load data for requester i is on rdata.
REQ-013 Port rdata  output  32  load data, shared by both requesters.
REQ-014 Port dmem_wren, funct3[2:0], dmem_address[31:0], dmem_data_in[31:0]  output  drive the data memory port.
REQ-015 Port dmem_data_out  input  32  data memory load result, valid RD_LATENCY cycles after the address.

Function
REQ-016 Arbitration SHALL be combinational: gnt is asserted in the same cycle as req, with zero-cycle grant latency.
REQ-017 The downstream mux SHALL select the granted requester's we, funct3, addr and wdata.
- When gnt==0: dmem_wren=0, funct3=3'b010, dmem_address=0, dmem_data_in=0.
REQ-018 dmem_wren SHALL equal req_we of the granted requester and SHALL be 0 when nothing is granted.
REQ-019 FSM states and transitions:
- FREE: round-robin between requesters.
- LOCK0 / LOCK1: ownership is fixed to that requester.
REQ-020 In FREE, a single requester SHALL be granted immediately.
- On a conflict, the requester not granted most recently wins; the rr pointer SHALL then update to the winner.
REQ-021 A granted access with its req_lock bit set SHALL move FREE->LOCKi.
REQ-022 In LOCKi, only requester i is eligible; the other requester SHALL be held with gnt=0 even while asserting req.
REQ-023 LOCKi SHALL exit to FREE after any cycle in which requester i is granted with req_lock[i]=0, or in which req[i]=0.
REQ-024 A lock SHALL last at most 4 consecutive cycles.
- A 2-bit hold counter forces LOCKi->FREE; the next FREE conflict is then won by the other requester.
REQ-025 For a granted load, rvalid[i] SHALL pulse exactly one cycle later with rdata=dmem_data_out.
- The load owner is registered; routing does not depend on current-cycle inputs.
REQ-026 Accesses SHALL pipeline: a new grant may issue in the same cycle rvalid is returned for the previous load.
- Back-to-back loads sustain 1 access per cycle.
REQ-027 Stores SHALL produce no rvalid.
REQ-028 When no load was granted in the previous cycle, rvalid SHALL be 0 and rdata SHALL be 0.
REQ-029 The arbiter SHALL NOT check address range or alignment; the data memory defines those semantics.

Reset
REQ-030 While reset is high, on each posedge:
- FSM<-FREE, rr pointer<-favour requester 0, hold counter<-0, pending-load flags<-0.
REQ-031 While reset is high, gnt=0, rvalid=0 and dmem_wren=0, regardless of req.
REQ-032 A load granted in the cycle before reset asserts SHALL NOT produce rvalid after reset.

Structure
REQ-033 The package dmem_arb_pkg SHALL hold:
- the FSM state enum;
- the LOCK_MAX=4 constant;
- the idle-default funct3 constant.
REQ-034 One sub-module, rr_arbiter2, SHALL be used: 2-input round-robin, combinational grant plus pointer register.
- The FSM, lock logic, mux and load-return pipeline stay in dmem_arbiter.

Verification
REQ-035 Single read: req=01, we=0, addr0=0x10, memory word 0x10=0xDEADBEEF.
- Expected: gnt=01 in cycle 0; rvalid=01 and rdata=0xDEADBEEF in cycle 1.
REQ-036 Conflict: req=11 held for 4 cycles after reset, all loads.
- Expected: gnt sequence 01,10,01,10; rvalid follows one cycle behind with matching owners.
REQ-037 Lock: requester1 lb with lock=1, then sb to 0x20 with lock=0, while req0 is held high.
- Expected: gnt=10,10,01; byte at 0x20 updated; requester0 access lands in the third cycle.
REQ-038 Lock timeout: req_lock[0]=1 held continuously with req=11.
- Expected: gnt=01 for exactly 4 cycles, then 10.
REQ-039 Reset mid-load: grant a load in cycle n and assert reset in cycle n+1.
- Expected: rvalid=0 in n+1 and n+2; after release, the first conflict grants requester 0.
REQ-040 Store: sw 0x12345678 to 0x40 by requester 0, then lw 0x40 by requester 1.
- Expected: dmem_wren=1 in cycle 0 only; rvalid=10 with rdata=0x12345678 in cycle 2.
